// File: rtl/ov7670_pkg.sv
// Shared OV7670 definitions: QVGA geometry, capture state encoding and pixel type.
// Imported by both the capture path and the SCCB configuration path.
package ov7670_pkg;

   localparam int QVGA_H_PIX   = 320;
   localparam int QVGA_V_LINES = 240;
   localparam int QVGA_ADDR_W  = 17;

   typedef enum logic [1:0] {
      CAP_IDLE    = 2'd0,
      CAP_WAIT_VS = 2'd1,
      CAP_FRAME   = 2'd2
   } cap_state_e;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_VS = 2'd1;
   localparam logic [1:0] ST_FRAME   = 2'd2;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

endpackage

// File: rtl/ov7670_rgb565_packer.sv
// Pairs camera bytes into RGB565 pixels: first byte is the high half, the second
// byte completes the pixel and raises the write strobe for one cycle.
module ov7670_rgb565_packer
   import ov7670_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic        clr_i,
   input  logic        accept_i,
   input  logic [7:0]  d_i,
   output logic        pix_o,
   output logic        phase_o,
   output logic        we_o,
   output logic [15:0] wdata_o
);

   logic       phase_q, phase_d;
   logic [7:0] hi_q, hi_d;
   logic       we_q, we_d;
   rgb565_t    px_q, px_d;

   assign pix_o   = en_i & phase_q;
   assign phase_o = phase_q;
   assign we_o    = we_q;
   assign wdata_o = px_q;

   always_comb begin
      phase_d = phase_q;
      hi_d    = hi_q;
      we_d    = 1'b0;
      px_d    = px_q;
      if (en_i) begin
         if (!phase_q) begin
            hi_d = d_i;
         end else if (accept_i) begin
            we_d = 1'b1;
            px_d = rgb565_t'({hi_q, d_i});
         end
         phase_d = ~phase_q;
      end
      // A line end or frame start discards any half-formed pixel.
      if (clr_i) phase_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= 1'b0;
         hi_q    <= '0;
         we_q    <= 1'b0;
         px_q    <= '0;
      end else begin
         phase_q <= phase_d;
         hi_q    <= hi_d;
         we_q    <= we_d;
         px_q    <= px_d;
      end
   end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: aligns to VSYNC/HREF after configuration completes and
// writes RGB565 pixels row-major into a frame buffer, flagging torn lines/frames.
module ov7670_capture
   import ov7670_pkg::*;
#(
   parameter int H_PIX   = QVGA_H_PIX,
   parameter int V_LINES = QVGA_V_LINES,
   parameter int ADDR_W  = QVGA_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cfg_done_i,
   input  logic              vsync_i,
   input  logic              href_i,
   input  logic [7:0]        d_i,
   output logic              we_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [15:0]       wdata_o,
   output logic              frame_done_o,
   output logic              line_err_o,
   output logic              capturing_o,
   output cap_state_e        dbg_state_o
);

   localparam int X_W = $clog2(H_PIX + 2);
   localparam int Y_W = $clog2(V_LINES + 2);
   localparam logic [X_W-1:0]    X_END     = X_W'(H_PIX);
   localparam logic [Y_W-1:0]    Y_END     = Y_W'(V_LINES);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIX);

   logic       vs_q, hr_q, vs_dly_q, hr_dly_q;
   logic [7:0] d_q;

   logic [1:0]        state_q, state_d;
   logic              armed_q, armed_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              err_q, err_d;
   logic              fdone_q, fdone_d;

   logic vs_rise, vs_fall, hr_fall;
   logic in_frame, frame_start, line_end;
   logic pk_en, pk_clr, accept, pix, phase;

   assign vs_rise     = vs_q & ~vs_dly_q;
   assign vs_fall     = ~vs_q & vs_dly_q;
   assign hr_fall     = ~hr_q & hr_dly_q;
   assign in_frame    = (state_q == ST_FRAME);
   assign frame_start = (state_q == ST_WAIT_VS) & vs_fall;
   // VSYNC rising with HREF still high closes the partial line first.
   assign line_end    = in_frame & (hr_fall | (vs_rise & hr_q));
   assign pk_en       = in_frame & hr_q & ~vs_rise;
   assign pk_clr      = frame_start | line_end;
   assign accept      = (x_q < X_END) && (y_q < Y_END);

   ov7670_rgb565_packer u_packer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (pk_en),
      .clr_i    (pk_clr),
      .accept_i (accept),
      .d_i      (d_q),
      .pix_o    (pix),
      .phase_o  (phase),
      .we_o     (we_o),
      .wdata_o  (wdata_o)
   );

   always_comb begin
      state_d = state_q;
      armed_d = armed_q;
      x_d     = x_q;
      y_d     = y_q;
      base_d  = base_q;
      waddr_d = waddr_q;
      err_d   = err_q;
      fdone_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_done_i || armed_q) begin
               armed_d = 1'b1;
               state_d = ST_WAIT_VS;
            end
         end
         ST_WAIT_VS: begin
            if (vs_fall) begin
               state_d = ST_FRAME;
               x_d     = '0;
               y_d     = '0;
               base_d  = '0;
               waddr_d = '0;
               err_d   = 1'b0;
            end
         end
         ST_FRAME: begin
            if (pix) begin
               if (accept) waddr_d = base_q + ADDR_W'(x_q);
               else        err_d   = 1'b1;
               // x saturates just past the line length so a long line still reads as wrong.
               if (x_q <= X_END) x_d = x_q + 1'b1;
            end
            if (line_end) begin
               if (phase || (x_q != X_END)) err_d = 1'b1;
               x_d = '0;
               if (y_q <= Y_END) y_d = y_q + 1'b1;
               if (y_q < Y_END) base_d = base_q + LINE_STEP;
            end
            if (vs_rise) begin
               if (y_d != Y_END) err_d = 1'b1;
               fdone_d = 1'b1;
               state_d = ST_WAIT_VS;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vs_q     <= 1'b0;
         hr_q     <= 1'b0;
         d_q      <= '0;
         vs_dly_q <= 1'b0;
         hr_dly_q <= 1'b0;
         state_q  <= ST_IDLE;
         armed_q  <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         base_q   <= '0;
         waddr_q  <= '0;
         err_q    <= 1'b0;
         fdone_q  <= 1'b0;
      end else begin
         vs_q     <= vsync_i;
         hr_q     <= href_i;
         d_q      <= d_i;
         vs_dly_q <= vs_q;
         hr_dly_q <= hr_q;
         state_q  <= state_d;
         armed_q  <= armed_d;
         x_q      <= x_d;
         y_q      <= y_d;
         base_q   <= base_d;
         waddr_q  <= waddr_d;
         err_q    <= err_d;
         fdone_q  <= fdone_d;
      end
   end

   assign waddr_o      = waddr_q;
   assign frame_done_o = fdone_q;
   assign line_err_o   = err_q;
   assign capturing_o  = in_frame;
   assign dbg_state_o  = cap_state_e'(state_q);

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture on a reduced 16x12 frame: frames of per-line byte counts
// are driven and every write is checked against a row-major pixel model.
module tb_ov7670_capture;
   import ov7670_pkg::*;

   localparam int H  = 16;
   localparam int V  = 12;
   localparam int AW = 8;
   localparam int EW = AW + 16;
   localparam int NO_LIMIT = 1 << 30;

   logic          clk = 1'b0;
   logic          rst_n, cfg_done, vsync, href;
   logic [7:0]    d;
   logic          we;
   logic [AW-1:0] waddr;
   logic [15:0]   wdata;
   logic          frame_done, line_err, capturing;
   cap_state_e    dbg_state;

   int compared   = 0;
   int mismatched = 0;
   int fd_cnt     = 0;
   int wr_cnt     = 0;
   bit cap_seen   = 1'b0;
   logic [EW-1:0] exp_q[$];
   int line_len[$];

   always #5 clk = ~clk;

   ov7670_capture #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cfg_done_i   (cfg_done),
      .vsync_i      (vsync),
      .href_i       (href),
      .d_i          (d),
      .we_o         (we),
      .waddr_o      (waddr),
      .wdata_o      (wdata),
      .frame_done_o (frame_done),
      .line_err_o   (line_err),
      .capturing_o  (capturing),
      .dbg_state_o  (dbg_state)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write must match the oldest expected {addr, pixel}.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (frame_done) fd_cnt++;
      if (capturing) cap_seen = 1'b1;
      if (we) begin
         wr_cnt++;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
         chk("write", {waddr, wdata}, e);
      end
   end

   function automatic logic [7:0] gen_byte(input int pat, input int i);
      if (pat == 0) return (i % 2 == 0) ? 8'hAB : 8'hCD;
      return 8'($urandom_range(0, 255));
   endfunction

   task automatic set_lines(input int n);
      line_len.delete();
      repeat (n) line_len.push_back(2 * H);
   endtask

   // Drives n bytes of line l with href high; models up to 'limit' pixels of it.
   task automatic drive_line(input int l, input int n, input int pat, input bit cap,
                             input int limit, output bit bad);
      logic [7:0] b[$];
      for (int i = 0; i < n; i++) b.push_back(gen_byte(pat, i));
      for (int k = 0; (2 * k + 1 < n) && (k < limit); k++)
         if (cap && k < H && l < V) exp_q.push_back({AW'(l * H + k), b[2*k], b[2*k+1]});
      bad = (n != 2 * H);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         href = 1'b1;
         d    = b[i];
      end
   endtask

   task automatic send_frame(input int pat, input bit cap, input bit sim_end);
      bit err, bad;
      int fd0;
      fd0 = fd_cnt;
      err = (line_len.size() != V);
      vsync = 1'b1; href = 1'b0;
      repeat (4) @(negedge clk);
      vsync = 1'b0;
      repeat (3) @(negedge clk);
      for (int l = 0; l < line_len.size(); l++) begin
         drive_line(l, line_len[l], pat, cap, NO_LIMIT, bad);
         err |= bad;
         if (l == 0) chk("capturing_in_line", capturing, cap);
         @(negedge clk);
         href = 1'b0;
         if (sim_end && l == line_len.size() - 1) vsync = 1'b1;
         else repeat (3) @(negedge clk);
      end
      vsync = 1'b1;
      @(negedge clk);
      chk("frame_done_early", frame_done, 0);
      @(negedge clk);
      chk("frame_done", frame_done, cap);
      chk("line_err_at_done", line_err, cap & err);
      chk("capturing_at_done", capturing, 0);
      repeat (3) @(negedge clk);
      chk("writes_outstanding", exp_q.size(), 0);
      chk("frame_done_pulses", fd_cnt - fd0, cap);
   endtask

   initial begin
      int wr0, fd0;
      bit bad;
      rst_n = 1'b0; cfg_done = 1'b0; vsync = 1'b1; href = 1'b0; d = '0;
      repeat (3) @(negedge clk);
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_line_err", line_err, 0);
      chk("rst_capturing", capturing, 0);
      chk("rst_state", dbg_state, CAP_IDLE);
      rst_n = 1'b1;
      @(negedge clk);

      // No configuration yet: a full frame must be ignored.
      set_lines(V); wr0 = wr_cnt;
      send_frame(0, 1'b0, 1'b0);
      chk("no_cfg_writes", wr_cnt - wr0, 0);
      chk("no_cfg_capturing", cap_seen, 0);
      chk("no_cfg_state", dbg_state, CAP_IDLE);

      cfg_done = 1'b1; @(negedge clk); cfg_done = 1'b0; @(negedge clk);
      chk("armed_state", dbg_state, CAP_WAIT_VS);

      wr0 = wr_cnt; send_frame(0, 1'b1, 1'b0);
      chk("full_writes", wr_cnt - wr0, H * V);

      wr0 = wr_cnt; send_frame(1, 1'b1, 1'b1);
      chk("simul_end_writes", wr_cnt - wr0, H * V);

      set_lines(V); line_len[5] = 2 * H - 4; wr0 = wr_cnt;
      send_frame(1, 1'b1, 1'b0);
      chk("short_line_writes", wr_cnt - wr0, H * V - 2);

      set_lines(V); line_len[0] = 2 * H + 4; wr0 = wr_cnt;
      send_frame(1, 1'b1, 1'b0);
      chk("long_line_writes", wr_cnt - wr0, H * V);

      set_lines(V); line_len[3] = 2 * H + 1; wr0 = wr_cnt;
      send_frame(1, 1'b1, 1'b0);
      chk("odd_line_writes", wr_cnt - wr0, H * V);
      chk("line_err_held", line_err, 1);
      set_lines(V);
      send_frame(1, 1'b1, 1'b0);

      set_lines(V - 1); send_frame(1, 1'b1, 1'b0);
      set_lines(V + 1); wr0 = wr_cnt;
      send_frame(1, 1'b1, 1'b1);
      chk("extra_line_writes", wr_cnt - wr0, H * V);

      repeat (3) begin
         set_lines(V);
         for (int l = 0; l < V; l++)
            if ($urandom_range(0, 3) == 0) line_len[l] = 2 * H - 3 + int'($urandom_range(0, 6));
         send_frame(1, 1'b1, 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of line 2; the pixel still in flight is lost.
      set_lines(V);
      vsync = 1'b1; repeat (4) @(negedge clk);
      vsync = 1'b0; repeat (3) @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         drive_line(l, 2 * H, 1, 1'b1, NO_LIMIT, bad);
         @(negedge clk); href = 1'b0;
         repeat (3) @(negedge clk);
      end
      drive_line(2, 10, 1, 1'b1, 4, bad);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_we", we, 0);
      chk("midrst_waddr", waddr, 0);
      chk("midrst_wdata", wdata, 0);
      chk("midrst_capturing", capturing, 0);
      chk("midrst_state", dbg_state, CAP_IDLE);
      chk("midrst_pending", exp_q.size(), 0);
      href = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cfg_done = 1'b1; @(negedge clk); cfg_done = 1'b0;
      wr0 = wr_cnt; fd0 = fd_cnt;
      for (int l = 0; l < 2; l++) begin
         drive_line(l, 2 * H, 1, 1'b0, NO_LIMIT, bad);
         @(negedge clk); href = 1'b0;
         repeat (3) @(negedge clk);
      end
      chk("rearm_no_writes", wr_cnt - wr0, 0);
      chk("rearm_no_done", fd_cnt - fd0, 0);
      chk("rearm_state", dbg_state, CAP_WAIT_VS);
      wr0 = wr_cnt;
      send_frame(0, 1'b1, 1'b0);
      chk("rearm_full_writes", wr_cnt - wr0, H * V);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
